// File: rtl/neuron_grid_sequencer.sv
`timescale 1ns/1ps
// Timestep sequencer for a neuron grid: walks every neuron through load,
// axon integration, optional leak and potential update, then hands off spikes.
//   state     | meaning
//   IDLE      | waiting for tick
//   LOAD      | fetch neuron state
//   INTEGRATE | sweep axons
//   LEAK      | apply leak
//   UPDATE    | update potential, offer spike
//   FINISH    | timestep done
module neuron_grid_sequencer #(
   parameter int NUM_NEURONS = 256,
   parameter int NUM_AXONS   = 256,
   parameter int MISS_W      = 8,
   localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   localparam int AW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick,
   input  logic              leak_en,
   input  logic              spike_in,
   input  logic              spike_ready,
   input  logic              error_clr,
   output logic [NW-1:0]     neuron_num,
   output logic [AW-1:0]     axon_num,
   output logic              scheduler_set,
   output logic              scheduler_clr,
   output logic              new_neuron,
   output logic              process_spike,
   output logic              leak_apply,
   output logic              update_potential,
   output logic              spike_valid,
   output logic [NW-1:0]     spike_neuron,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [MISS_W-1:0] miss_count
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_INTEGRATE = 3'd2,
      S_LEAK      = 3'd3,
      S_UPDATE    = 3'd4,
      S_FINISH    = 3'd5
   } state_t;

   localparam logic [NW-1:0]     NEURON_LAST = NW'(NUM_NEURONS - 1);
   localparam logic [AW-1:0]     AXON_LAST   = AW'(NUM_AXONS - 1);
   localparam logic [MISS_W-1:0] MISS_MAX    = {MISS_W{1'b1}};

   state_t            r_state, w_state_nxt;
   logic [NW-1:0]     r_neuron;
   logic [AW-1:0]     r_axon;
   logic              r_leak_mode;
   logic              r_upd_first;
   logic              r_error;
   logic [MISS_W-1:0] r_miss;
   logic              w_last_axon, w_last_neuron, w_upd_exit, w_miss_tick;

   assign w_last_axon   = (r_axon == AXON_LAST);
   assign w_last_neuron = (r_neuron == NEURON_LAST);
   assign w_upd_exit    = ~spike_in | spike_ready;
   assign w_miss_tick   = tick & (r_state != S_IDLE);

   assign neuron_num   = r_neuron;
   assign axon_num     = r_axon;
   assign spike_neuron = r_neuron;
   assign error        = r_error;
   assign miss_count   = r_miss;

   always_comb begin
      w_state_nxt      = r_state;
      scheduler_set    = 1'b0;
      scheduler_clr    = 1'b0;
      new_neuron       = 1'b0;
      process_spike    = 1'b0;
      leak_apply       = 1'b0;
      update_potential = 1'b0;
      spike_valid      = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tick) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            busy          = 1'b1;
            new_neuron    = 1'b1;
            scheduler_set = (r_neuron == '0);
            w_state_nxt   = S_INTEGRATE;
         end
         S_INTEGRATE: begin
            busy          = 1'b1;
            process_spike = 1'b1;
            if (w_last_axon) w_state_nxt = r_leak_mode ? S_LEAK : S_UPDATE;
         end
         S_LEAK: begin
            busy        = 1'b1;
            leak_apply  = 1'b1;
            w_state_nxt = S_UPDATE;
         end
         S_UPDATE: begin
            busy             = 1'b1;
            update_potential = r_upd_first;
            spike_valid      = spike_in;
            if (w_upd_exit) w_state_nxt = w_last_neuron ? S_FINISH : S_LOAD;
         end
         S_FINISH: begin
            busy          = 1'b1;
            scheduler_clr = 1'b1;
            done          = 1'b1;
            w_state_nxt   = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // r_upd_first marks only the entry cycle of UPDATE so a stall does not repeat the update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_upd_first <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_upd_first <= (w_state_nxt == S_UPDATE) && (r_state != S_UPDATE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_neuron    <= '0;
         r_axon      <= '0;
         r_leak_mode <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (tick) begin
                  r_neuron    <= '0;
                  r_axon      <= '0;
                  r_leak_mode <= leak_en;
               end
            end
            S_LOAD:      r_axon <= '0;
            S_INTEGRATE: if (!w_last_axon) r_axon <= r_axon + 1'b1;
            S_UPDATE:    if (w_upd_exit && !w_last_neuron) r_neuron <= r_neuron + 1'b1;
            default: ;
         endcase
      end
   end

   // A dropped tick outranks a same-cycle clear so the drop is never lost
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_error <= 1'b0;
         r_miss  <= '0;
      end else if (w_miss_tick) begin
         r_error <= 1'b1;
         if (error_clr)              r_miss <= MISS_W'(1);
         else if (r_miss != MISS_MAX) r_miss <= r_miss + 1'b1;
      end else if (error_clr) begin
         r_error <= 1'b0;
         r_miss  <= '0;
      end
   end

endmodule

// File: tb/tb_neuron_grid_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench: expected per-cycle strobe timelines are expanded from the
// timestep rules; latency, miss counting, reset abort and saturation are checked.
module tb_neuron_grid_sequencer;
   localparam int N = 4;
   localparam int A = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0, leak_en = 1'b0, spike_in = 1'b0, spike_ready = 1'b1, error_clr = 1'b0;
   logic [1:0] neuron_num, spike_neuron;
   logic [2:0] axon_num;
   logic       scheduler_set, scheduler_clr, new_neuron, process_spike, leak_apply;
   logic       update_potential, spike_valid, busy, done, error;
   logic [7:0] miss_count;

   logic       tick2 = 1'b0;
   logic       neuron_num2, axon_num2, spike_neuron2;
   logic       sset2, sclr2, nn2, ps2, la2, up2, sv2, busy2, done2, error2;
   logic [1:0] miss2;

   always #5 clk = ~clk;

   neuron_grid_sequencer #(.NUM_NEURONS(N), .NUM_AXONS(A), .MISS_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .leak_en(leak_en), .spike_in(spike_in),
      .spike_ready(spike_ready), .error_clr(error_clr), .neuron_num(neuron_num),
      .axon_num(axon_num), .scheduler_set(scheduler_set), .scheduler_clr(scheduler_clr),
      .new_neuron(new_neuron), .process_spike(process_spike), .leak_apply(leak_apply),
      .update_potential(update_potential), .spike_valid(spike_valid),
      .spike_neuron(spike_neuron), .busy(busy), .done(done), .error(error),
      .miss_count(miss_count));

   neuron_grid_sequencer #(.NUM_NEURONS(1), .NUM_AXONS(1), .MISS_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .tick(tick2), .leak_en(1'b0), .spike_in(1'b0),
      .spike_ready(1'b1), .error_clr(1'b0), .neuron_num(neuron_num2),
      .axon_num(axon_num2), .scheduler_set(sset2), .scheduler_clr(sclr2),
      .new_neuron(nn2), .process_spike(ps2), .leak_apply(la2),
      .update_potential(up2), .spike_valid(sv2), .spike_neuron(spike_neuron2),
      .busy(busy2), .done(done2), .error(error2), .miss_count(miss2));

   int n_checks = 0;
   int n_errors = 0;
   bit m_err = 1'b0;
   int m_miss = 0;

   typedef struct {
      bit sset, sclr, nn, ps, la, up, sv, bsy, dn;
      bit upd_st, sin, srdy;
      int nidx, aidx;
   } cyc_t;

   typedef struct {
      bit leak; bit [3:0] spk; int stall_n; int stall_len;
      int t1, t2, t3, clr_at; int exp_done; bit exp_err; int exp_miss; bit clr_after;
   } vec_t;

   cyc_t tl[$];

   task automatic chk(input bit ok, input string name, input int got, input int exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic cyc_t mk(input int n);
      cyc_t e;
      e.sset = 0; e.sclr = 0; e.nn = 0; e.ps = 0; e.la = 0; e.up = 0; e.sv = 0;
      e.bsy = 1; e.dn = 0; e.upd_st = 0; e.sin = 0; e.srdy = 0;
      e.nidx = n; e.aidx = -1;
      return e;
   endfunction

   // Expand one timestep into its expected cycle-by-cycle behaviour
   task automatic build_tl(input bit leak, input bit [3:0] spk, input int stall_n, input int stall_len);
      cyc_t e;
      int stalls;
      tl.delete();
      for (int n = 0; n < N; n++) begin
         e = mk(n); e.nn = 1; e.sset = (n == 0); tl.push_back(e);
         for (int a = 0; a < A; a++) begin
            e = mk(n); e.ps = 1; e.aidx = a; tl.push_back(e);
         end
         if (leak) begin
            e = mk(n); e.la = 1; tl.push_back(e);
         end
         stalls = (spk[n] && n == stall_n) ? stall_len : 0;
         for (int s = 0; s <= stalls; s++) begin
            e = mk(n); e.upd_st = 1; e.up = (s == 0);
            e.sin = spk[n]; e.sv = spk[n];
            e.srdy = spk[n] ? (s == stalls) : 1'($urandom);
            tl.push_back(e);
         end
      end
      e = mk(N - 1); e.sclr = 1; e.dn = 1; tl.push_back(e);
   endtask

   // Entered and left 2 time units after a rising edge with the DUT idle
   task automatic run_ts(input bit leak, input bit [3:0] spk, input int stall_n, input int stall_len,
                         input int t1, input int t2, input int t3, input int clr_at, output int done_c);
      cyc_t e;
      logic [8:0] got_v, exp_v;
      int cnt_ps, cnt_set, cnt_clr, cnt_la;
      bit ok;
      build_tl(leak, spk, stall_n, stall_len);
      cnt_ps = 0; cnt_set = 0; cnt_clr = 0; cnt_la = 0;
      tick = 1'b1; leak_en = leak; error_clr = 1'b0; spike_in = 1'($urandom);
      @(posedge clk);
      #1;
      done_c = -1;
      for (int c = 1; c <= tl.size(); c++) begin
         e = tl[c-1];
         tick = (c == t1 || c == t2 || c == t3);
         error_clr = (c == clr_at);
         leak_en = 1'($urandom);
         if (e.upd_st) begin
            spike_in = e.sin; spike_ready = e.srdy;
         end else begin
            spike_in = 1'($urandom); spike_ready = 1'($urandom);
         end
         #1;
         got_v = {scheduler_set, scheduler_clr, new_neuron, process_spike, leak_apply,
                  update_potential, spike_valid, busy, done};
         exp_v = {e.sset, e.sclr, e.nn, e.ps, e.la, e.up, e.sv, e.bsy, e.dn};
         ok = (got_v == exp_v) && (int'(neuron_num) == e.nidx) &&
              (e.aidx < 0 || int'(axon_num) == e.aidx) &&
              (!e.sv || int'(spike_neuron) == e.nidx);
         chk(ok, $sformatf("cyc%0d strobes n=%0d/%0d a=%0d/%0d", c, neuron_num, e.nidx,
             axon_num, e.aidx), int'(got_v), int'(exp_v));
         if (done && done_c < 0) done_c = c;
         cnt_ps += int'(process_spike); cnt_set += int'(scheduler_set);
         cnt_clr += int'(scheduler_clr); cnt_la += int'(leak_apply);
         @(posedge clk);
         if (tick) begin
            m_err = 1'b1;
            m_miss = error_clr ? 1 : ((m_miss == 255) ? 255 : m_miss + 1);
         end else if (error_clr) begin
            m_err = 1'b0; m_miss = 0;
         end
         #1;
      end
      tick = 1'b0; error_clr = 1'b0; spike_in = 1'b0; spike_ready = 1'b1;
      #1;
      chk(!busy && !done, "idle_after_finish", int'({busy, done}), 0);
      chk(error == m_err && int'(miss_count) == m_miss, "err_miss_model",
          int'({error, miss_count}), int'({m_err, 8'(m_miss)}));
      chk(cnt_ps == N*A && cnt_set == 1 && cnt_clr == 1 && cnt_la == (leak ? N : 0),
          "strobe_counts", cnt_ps*1000 + cnt_set*100 + cnt_clr*10 + cnt_la,
          N*A*1000 + 110 + (leak ? N : 0));
   endtask

   task automatic clear_errors();
      error_clr = 1'b1;
      @(posedge clk);
      m_err = 1'b0; m_miss = 0;
      #1 error_clr = 1'b0;
      #1 chk(!error && miss_count == 0, "error_clr", int'({error, miss_count}), 0);
   endtask

   vec_t vecs[7];
   int dc, exp_dc, m2;
   logic [8:0] g2, e2;
   int p;

   initial begin
      //          leak spk      sn sl  t1 t2 t3  clr done err miss clr_after
      vecs[0] = '{1'b0, 4'b0000, 0, 0,  0, 0, 0,  0, 41, 1'b0, 0, 1'b0};
      vecs[1] = '{1'b1, 4'b0000, 0, 0,  0, 0, 0,  0, 45, 1'b0, 0, 1'b0};
      vecs[2] = '{1'b0, 4'b0100, 2, 3,  0, 0, 0,  0, 44, 1'b0, 0, 1'b0};
      vecs[3] = '{1'b0, 4'b0000, 0, 0,  1, 3, 41, 0, 41, 1'b1, 3, 1'b0};
      vecs[4] = '{1'b1, 4'b1111, 0, 0,  2, 3, 0,  3, 45, 1'b1, 1, 1'b1};
      vecs[5] = '{1'b1, 4'b1010, 3, 2,  0, 0, 0,  0, 47, 1'b0, 0, 1'b0};
      vecs[6] = '{1'b0, 4'b0001, 0, 1,  42, 0, 0, 0, 42, 1'b1, 1, 1'b1};

      spike_in = 1'b1;
      #2;
      chk({scheduler_set, scheduler_clr, new_neuron, process_spike, leak_apply, update_potential,
           spike_valid, busy, done, error, miss_count, neuron_num, axon_num} == '0,
          "reset_state", int'(busy), 0);
      @(negedge clk) reset_n = 1'b1;
      spike_in = 1'b0;
      @(posedge clk);
      #2;

      foreach (vecs[i]) begin
         run_ts(vecs[i].leak, vecs[i].spk, vecs[i].stall_n, vecs[i].stall_len,
                vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].clr_at, dc);
         chk(dc == vecs[i].exp_done, $sformatf("vec%0d done_latency", i), dc, vecs[i].exp_done);
         chk(error == vecs[i].exp_err && int'(miss_count) == vecs[i].exp_miss,
             $sformatf("vec%0d err_miss", i), int'({error, miss_count}),
             int'({vecs[i].exp_err, 8'(vecs[i].exp_miss)}));
         if (vecs[i].clr_after) clear_errors();
      end

      for (int r = 0; r < 12; r++) begin
         bit lk; bit [3:0] sp; int sn, sl;
         lk = 1'($urandom); sp = 4'($urandom);
         sn = $urandom_range(0, 3); sl = $urandom_range(0, 4);
         exp_dc = 1 + N*(A + 2 + int'(lk)) + (sp[sn] ? sl : 0);
         run_ts(lk, sp, sn, sl, $urandom_range(0, 50), $urandom_range(0, 50),
                $urandom_range(0, 50), $urandom_range(0, 70), dc);
         chk(dc == exp_dc, $sformatf("rand%0d done_latency", r), dc, exp_dc);
      end

      // Abort mid-integration of neuron 1, after a dropped tick set the error flag
      tick = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c < 14; c++) begin
         tick = (c == 2);
         @(posedge clk);
         #1;
      end
      tick = 1'b0; spike_in = 1'b1;
      #1;
      chk(neuron_num == 2'd1 && axon_num == 3'd2 && process_spike && error,
          "pre_reset_position", int'({neuron_num, axon_num}), int'({2'd1, 3'd2}));
      reset_n = 1'b0;
      #1;
      chk({scheduler_set, scheduler_clr, new_neuron, process_spike, leak_apply, update_potential,
           spike_valid, busy, done, error, miss_count, neuron_num, axon_num} == '0,
          "async_reset_clears", int'({busy, error, neuron_num, axon_num}), 0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk(!done && !busy && !scheduler_clr, "no_done_in_reset", int'({done, busy}), 0);
      end
      #1;
      reset_n = 1'b1; spike_in = 1'b0;
      m_err = 1'b0; m_miss = 0;
      run_ts(1'b0, 4'b0000, 0, 0, 0, 0, 0, 0, dc);
      chk(dc == 41, "post_reset_latency", dc, 41);

      // Single neuron, single axon, 2-bit miss counter: 5 busy ticks saturate at 3
      m2 = 0;
      tick2 = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c <= 10; c++) begin
         tick2 = (c <= 6);
         #1;
         p = (c <= 5) ? c : c - 5;
         e2 = {p == 1, p == 4, p == 1, p == 2, 1'b0, p == 3, 1'b0, p != 5, p == 4};
         g2 = {sset2, sclr2, nn2, ps2, la2, up2, sv2, busy2, done2};
         chk(g2 == e2 && int'(miss2) == m2 && !neuron_num2 && !axon_num2 && !spike_neuron2,
             $sformatf("small_grid cyc%0d miss=%0d/%0d", c, miss2, m2), int'(g2), int'(e2));
         @(posedge clk);
         if (tick2 && p != 5) m2 = (m2 == 3) ? 3 : m2 + 1;
         #1;
      end
      tick2 = 1'b0;
      #1;
      chk(miss2 == 2'd3 && error2, "miss_saturation", int'(miss2), 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
